fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the always-taken pipelined RV32I core.
- Holds the PC and drives the instruction-memory address.
- Predecodes the fetched word and statically predicts every B-type branch and JAL as taken.
- Consumes the hazard unit's fetch/decode stall and flush controls plus the execute-stage redirects, and delivers PC, instruction and prediction flag to decode.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, instruction word inserted as a bubble (addi x0,x0,0)

Ports:
i_clk  in  1  clock, all state updates on rising edge
i_reset  in  1  asynchronous active-low reset
i_imem_rdata  in  32  instruction word at o_imem_addr (combinational read, same cycle)
i_stall_fetch  in  1  hold PC (from hazard unit)
i_stall_decode  in  1  hold IF/ID register (from hazard unit)
i_flush_decode  in  1  bubble IF/ID register (from hazard unit)
i_pc_sel  in  1  execute redirect: taken jump/branch whose target was not predicted
i_redirect_pc  in  32  target for i_pc_sel
i_out_loop  in  1  execute detected mispredicted-taken branch (actually not taken)
i_recover_pc  in  32  fall-through address (branch PC+4) for i_out_loop
o_imem_addr  out  32  current fetch PC
o_pc_decode  out  32  PC of instruction in decode
o_instr_decode  out  32  instruction in decode
o_pred_taken_decode  out  1  decode instruction was predicted taken
o_valid_decode  out  1  decode slot holds a real instruction (0 = bubble)

Behaviour:
- Reset (i_reset=0, asynchronous): PC=RESET_PC; o_pc_decode=0; o_instr_decode=NOP_INSTR; o_pred_taken_decode=0; o_valid_decode=0. First fetch occurs in the first cycle after reset deasserts.
- o_imem_addr = PC (combinational from register, no latency).
- Predecode on i_imem_rdata, combinational:
  - opcode 7'b1100011 (B-type): pred=1, target=PC+sext(imm_b).
  - opcode 7'b1101111 (JAL): pred=1, target=PC+sext(imm_j).
  - All others, including JALR: pred=0, target=PC+4.
  - Immediates are sign-extended to 32 bits; additions are modulo 2^32 (wrap at 32'hFFFF_FFFC+4 -> 0).
- Next-PC priority, highest first:
  1. i_pc_sel -> i_redirect_pc.
  2. i_out_loop -> i_recover_pc.
  3. i_stall_fetch -> hold PC.
  4. pred=1 -> predecoded target.
  5. else PC+4.
- Redirects override stall, so a load-use stall coinciding with a redirect still redirects.
- Every loaded PC has bits [1:0] forced to 2'b00.
- IF/ID register priority, highest first:
  1. i_flush_decode -> bubble: pc=0, instr=NOP_INSTR, pred=0, valid=0.
  2. i_stall_decode -> hold all four fields.
  3. Otherwise capture PC, i_imem_rdata, pred, valid=1.
- Flush wins over a simultaneous stall.
- Latency: an instruction at PC appears on decode outputs one cycle after PC is presented.
- A predicted-taken instruction costs zero bubbles. The instruction fetched at the target enters decode in the next cycle.
- Simultaneous i_pc_sel and i_out_loop: i_pc_sel wins.
- i_redirect_pc and i_recover_pc are ignored when their enable is low.
- Reset asserted mid-operation clears all state immediately, regardless of stall or flush.
- No other internal state: fetch is stateless apart from the PC and IF/ID registers.

Test Plan:
- Reset, then imem returns 32'h0000_0013 for all addresses -> o_imem_addr 0,4,8,12 on successive cycles; o_valid_decode=0 in cycle 1, then 1 with o_pc_decode trailing o_imem_addr by one cycle.
- PC=0x10 fetches beq with imm_b=-8 (32'hFE000CE3) -> next o_imem_addr=0x08; decode shows pc=0x10, pred=1. JAL imm=+0x100 at 0x20 -> next PC 0x120.
- i_stall_fetch=i_stall_decode=1 for 2 cycles at PC=0x40 -> o_imem_addr stays 0x40 and decode outputs unchanged. Release -> 0x44 next.
- i_out_loop=1 with i_recover_pc=0x14 and i_flush_decode=1 -> next o_imem_addr=0x14; decode becomes instr=0x0000_0013, valid=0, pred=0.
- i_pc_sel=1 (i_redirect_pc=0x200), i_out_loop=1 (i_recover_pc=0x30), i_stall_fetch=1 and i_stall_decode=1 together -> PC=0x200 and decode bubbled. i_redirect_pc=0x203 -> PC=0x200.
- Assert i_reset=0 asynchronously mid-cycle with PC=0x80 -> PC=RESET_PC and decode bubbled without waiting for a clock edge. PC=0xFFFF_FFFC with a non-branch -> next PC=0x0.

Source files
------------

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage plus IF/ID pipeline register of the always-taken
//   pipelined RV32I core. Holds the PC, drives the instruction-memory address,
//   predecodes the fetched word and predicts every B-type branch and JAL as
//   taken, so the predicted target is fetched on the very next cycle.
//
// Ports
//   i_clk               clock, rising-edge
//   i_reset             asynchronous active-low reset
//   i_imem_rdata        instruction word at o_imem_addr (same-cycle read)
//   i_stall_fetch       hold PC
//   i_stall_decode      hold IF/ID register
//   i_flush_decode      load a bubble into IF/ID
//   i_pc_sel            execute redirect to i_redirect_pc (highest priority)
//   i_redirect_pc       redirect target
//   i_out_loop          mispredicted-taken branch, resume at i_recover_pc
//   i_recover_pc        fall-through address for i_out_loop
//   o_imem_addr         current fetch PC
//   o_pc_decode         PC of the instruction in decode
//   o_instr_decode      instruction in decode
//   o_pred_taken_decode decode instruction was predicted taken
//   o_valid_decode      decode slot holds a real instruction
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_stall_fetch,
    input  logic        i_stall_decode,
    input  logic        i_flush_decode,
    input  logic        i_pc_sel,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_out_loop,
    input  logic [31:0] i_recover_pc,
    output logic [31:0] o_imem_addr,
    output logic [31:0] o_pc_decode,
    output logic [31:0] o_instr_decode,
    output logic        o_pred_taken_decode,
    output logic        o_valid_decode
);

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    logic [31:0] pc_q,    pc_d;
    logic [31:0] dpc_q,   dpc_d;
    logic [31:0] dinst_q, dinst_d;
    logic        dpred_q, dpred_d;
    logic        dvld_q,  dvld_d;

    logic [6:0]  opcode;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic        pred;
    logic [31:0] pred_target;
    logic [31:0] pc_next;

    // ---------------- predecode ----------------
    assign opcode = i_imem_rdata[6:0];
    assign imm_b  = {{20{i_imem_rdata[31]}}, i_imem_rdata[7],
                     i_imem_rdata[30:25], i_imem_rdata[11:8], 1'b0};
    assign imm_j  = {{12{i_imem_rdata[31]}}, i_imem_rdata[19:12],
                     i_imem_rdata[20], i_imem_rdata[30:21], 1'b0};

    always_comb begin
        pred        = 1'b0;
        pred_target = pc_q + 32'd4;
        unique case (opcode)
            OPC_BRANCH: begin
                pred        = 1'b1;
                pred_target = pc_q + imm_b;
            end
            OPC_JAL: begin
                pred        = 1'b1;
                pred_target = pc_q + imm_j;
            end
            default: ;
        endcase
    end

    // ---------------- next PC ----------------
    // Redirects are checked ahead of the fetch stall so a load-use stall
    // coinciding with a resolve in execute still steers the PC.
    always_comb begin
        pc_next = pc_q + 32'd4;
        if (i_pc_sel)
            pc_next = i_redirect_pc;
        else if (i_out_loop)
            pc_next = i_recover_pc;
        else if (i_stall_fetch)
            pc_next = pc_q;
        else if (pred)
            pc_next = pred_target;
        pc_d = {pc_next[31:2], 2'b00};
    end

    // ---------------- IF/ID next state ----------------
    always_comb begin
        dpc_d   = pc_q;
        dinst_d = i_imem_rdata;
        dpred_d = pred;
        dvld_d  = 1'b1;
        if (i_flush_decode) begin
            dpc_d   = '0;
            dinst_d = NOP_INSTR;
            dpred_d = 1'b0;
            dvld_d  = 1'b0;
        end else if (i_stall_decode) begin
            dpc_d   = dpc_q;
            dinst_d = dinst_q;
            dpred_d = dpred_q;
            dvld_d  = dvld_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            pc_q    <= {RESET_PC[31:2], 2'b00};
            dpc_q   <= '0;
            dinst_q <= NOP_INSTR;
            dpred_q <= 1'b0;
            dvld_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            dpc_q   <= dpc_d;
            dinst_q <= dinst_d;
            dpred_q <= dpred_d;
            dvld_q  <= dvld_d;
        end
    end

    assign o_imem_addr         = pc_q;
    assign o_pc_decode         = dpc_q;
    assign o_instr_decode      = dinst_q;
    assign o_pred_taken_decode = dpred_q;
    assign o_valid_decode      = dvld_q;

endmodule
